// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants, receiver FSM state codes and
// baud-divisor helpers used by the receiver and, later, the transmitter.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_START     = 3'd1;
   localparam state_t ST_DATA      = 3'd2;
   localparam state_t ST_STOP      = 3'd3;
   localparam state_t ST_WAIT_HIGH = 3'd4;

   // Whole clock cycles per bit; callers must keep the result >= 4.
   function automatic int calc_divisor(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

   function automatic int calc_half(input int divisor);
      return divisor / 2;
   endfunction

   function automatic int frame_cycles(input int divisor);
      return divisor * (1 + DATA_BITS + STOP_BITS);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a parameterised reset
// value so an idle-high line does not look like activity coming out of reset.
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // NOTE: non-blocking assignments make both stages sample their pre-edge values, so the chain really is two flops deep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, samples each bit mid-period and
// hands bytes over through a one-entry valid/ready holding register.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_rx,
   output logic [7:0] io_rx_bits,
   output logic       io_rx_valid,
   input  logic       io_rx_ready,
   output logic       io_framing_error,
   output logic       io_overrun,
   output logic       io_busy
);

   localparam int DIVISOR = calc_divisor(CLOCK_FREQ, BAUD_RATE);
   localparam int HALF    = calc_half(DIVISOR);
   localparam int CNT_W   = $clog2(DIVISOR);

   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(DIVISOR - 1);
   localparam logic [2:0]       LAST_BIT_IDX  = 3'(DATA_BITS - 1);

   logic rx_s;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;

   logic [7:0] bits_q, bits_d;
   logic       valid_q, valid_d;
   logic       framing_error_q, framing_error_d;
   logic       overrun_q, overrun_d;

   logic       byte_done;
   logic       stop_bad;

   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk   (clock),
      .rst_n (reset),
      .d     (io_rx),
      .q     (rx_s)
   );

   // NOTE: every signal written here gets a default first, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_done = 1'b0;
      stop_bad  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end

         // A start bit must still be low half a bit later, otherwise it was a glitch.
         ST_START: begin
            if (cnt_q == CNT_HALF_LAST) begin
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (cnt_q == CNT_BIT_LAST) begin
               shift_d[bit_idx_q] = rx_s;
               cnt_d              = '0;
               if (bit_idx_q == LAST_BIT_IDX) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_STOP: begin
            if (cnt_q == CNT_BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_done = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  stop_bad = 1'b1;
                  state_d  = ST_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // A held-low line (break) must return high before another frame can start.
         ST_WAIT_HIGH: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      bits_d          = bits_q;
      valid_d         = valid_q;
      framing_error_d = stop_bad;
      overrun_d       = 1'b0;

      if (valid_q && io_rx_ready) begin
         valid_d = 1'b0;
      end

      // A consumer taking the old byte this cycle frees the slot for the new one.
      if (byte_done) begin
         if (!valid_q || io_rx_ready) begin
            bits_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // NOTE: the shift register and holding register are reset as well, so io_rx_bits reads 0 from reset rather than X.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         bit_idx_q       <= '0;
         shift_q         <= '0;
         bits_q          <= '0;
         valid_q         <= 1'b0;
         framing_error_q <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         bit_idx_q       <= bit_idx_d;
         shift_q         <= shift_d;
         bits_q          <= bits_d;
         valid_q         <= valid_d;
         framing_error_q <= framing_error_d;
         overrun_q       <= overrun_d;
      end
   end

   assign io_rx_bits       = bits_q;
   assign io_rx_valid      = valid_q;
   assign io_framing_error = framing_error_q;
   assign io_overrun       = overrun_q;
   assign io_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level model predicts delivered bytes,
// framing errors and overruns; a per-cycle monitor checks the DUT against it.
module tb_uart_rx;

   localparam int CLOCK_FREQ  = 1_000_000;
   localparam int BAUD_RATE   = 100_000;
   localparam int HALF        = 5;
   localparam int CLK_PERIOD  = 1000;
   localparam int BAUD_PERIOD = 10_000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       io_rx = 1'b1;
   logic       io_rx_ready = 1'b1;
   logic [7:0] io_rx_bits;
   logic       io_rx_valid;
   logic       io_framing_error;
   logic       io_overrun;
   logic       io_busy;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic       model_full = 1'b0;
   int         exp_fe  = 0;
   int         exp_ovr = 0;
   int         beats    = 0;
   int         fe_seen  = 0;
   int         ovr_seen = 0;

   uart_rx #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .BAUD_RATE  (BAUD_RATE)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .io_rx            (io_rx),
      .io_rx_bits       (io_rx_bits),
      .io_rx_valid      (io_rx_valid),
      .io_rx_ready      (io_rx_ready),
      .io_framing_error (io_framing_error),
      .io_overrun       (io_overrun),
      .io_busy          (io_busy)
   );

   always #(CLK_PERIOD / 2) clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: outcome of a frame is decided from its stop bit, the
   // model's own occupancy of the holding slot and the (stable) ready level.
   task automatic model_frame(input logic [7:0] b, input logic stop);
      if (!stop) begin
         exp_fe++;
      end else if (model_full && !io_rx_ready) begin
         exp_ovr++;
      end else begin
         exp_q.push_back(b);
         model_full = !io_rx_ready;
      end
   endtask

   task automatic uart_send(input logic [7:0] b, input logic stop, input logic modelled);
      if (modelled) model_frame(b, stop);
      io_rx = 1'b0;
      #(BAUD_PERIOD);
      for (int i = 0; i < 8; i++) begin
         io_rx = b[i];
         #(BAUD_PERIOD);
      end
      io_rx = stop;
      #(BAUD_PERIOD);
      io_rx = 1'b1;
   endtask

   task automatic align();
      @(negedge clock);
      #100;
   endtask

   task automatic set_ready(input logic r);
      @(posedge clock);
      #1;
      io_rx_ready = r;
      if (r) model_full = 1'b0;
   endtask

   // Per-cycle compare against the model, sampled on the falling edge.
   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic       prev_fe    = 1'b0;
   logic       prev_ovr   = 1'b0;
   logic [7:0] prev_bits  = 8'h00;

   always @(negedge clock) begin : monitor
      logic [7:0] e;
      if (!reset) begin
         prev_valid <= 1'b0;
         prev_ready <= 1'b0;
         prev_fe    <= 1'b0;
         prev_ovr   <= 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("hold_valid", io_rx_valid, 1);
            check("hold_bits", io_rx_bits, prev_bits);
         end
         if (io_rx_valid && io_rx_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
               check("beat_expected", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("beat_bits", io_rx_bits, e);
            end
         end
         if (io_framing_error) begin
            fe_seen++;
            check("fe_single_cycle", prev_fe, 0);
            check("fe_without_overrun", io_overrun, 0);
         end
         if (io_overrun) begin
            ovr_seen++;
            check("ovr_single_cycle", prev_ovr, 0);
         end
         prev_valid <= io_rx_valid;
         prev_ready <= io_rx_ready;
         prev_bits  <= io_rx_bits;
         prev_fe    <= io_framing_error;
         prev_ovr   <= io_overrun;
      end
   end

   initial begin : watchdog
      #(20_000_000);
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int b0, f0, o0, n, busy_cnt;

      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_valid", io_rx_valid, 0);
      check("rst_bits", io_rx_bits, 0);
      check("rst_fe", io_framing_error, 0);
      check("rst_ovr", io_overrun, 0);
      check("rst_busy", io_busy, 0);
      reset = 1'b1;
      repeat (5) @(posedge clock);

      // Single byte 0x55 with latency measured from the io_rx falling edge
      b0 = beats;
      align();
      fork
         uart_send(8'h55, 1'b1, 1'b1);
         begin
            n = 0;
            while (!io_rx_valid && n < 200) begin
               @(posedge clock);
               #1;
               n++;
            end
            check("lat_55_in_96_98", (n >= 96 && n <= 98), 1);
            check("bits_55", io_rx_bits, 8'h55);
         end
      join
      repeat (20) @(posedge clock);
      check("beats_55", beats - b0, 1);
      check("fe_after_55", fe_seen, 0);

      // Back-to-back 0xA5, 0x3C; line idle between frames
      b0 = beats;
      align();
      fork
         begin
            uart_send(8'hA5, 1'b1, 1'b1);
            uart_send(8'h3C, 1'b1, 1'b1);
         end
         begin
            n = 0;
            while (!io_rx_valid && n < 200) begin
               @(posedge clock);
               #1;
               n++;
            end
            check("bits_a5", io_rx_bits, 8'hA5);
            check("busy_gap_low", io_busy, 0);
         end
      join
      repeat (20) @(posedge clock);
      check("beats_a5_3c", beats - b0, 2);
      check("ovr_after_b2b", ovr_seen, 0);

      // Holding register full: second byte overruns, first byte kept
      b0 = beats;
      o0 = ovr_seen;
      set_ready(1'b0);
      align();
      uart_send(8'h11, 1'b1, 1'b1);
      uart_send(8'h22, 1'b1, 1'b1);
      repeat (20) @(posedge clock);
      check("ovr_once", ovr_seen - o0, 1);
      @(negedge clock);
      check("held_valid", io_rx_valid, 1);
      check("held_bits_11", io_rx_bits, 8'h11);
      set_ready(1'b1);
      @(posedge clock);
      #1;
      check("valid_cleared", io_rx_valid, 0);
      repeat (5) @(posedge clock);
      check("beats_overrun", beats - b0, 1);

      // Break: 10 bit periods low, 2 high, then 0x7E
      b0 = beats;
      f0 = fe_seen;
      align();
      uart_send(8'h00, 1'b0, 1'b1);
      io_rx = 1'b1;
      #(2 * BAUD_PERIOD);
      uart_send(8'h7E, 1'b1, 1'b1);
      repeat (20) @(posedge clock);
      check("break_fe_once", fe_seen - f0, 1);
      check("beats_break", beats - b0, 1);

      // Short glitch: 3 cycles low
      b0 = beats;
      f0 = fe_seen;
      o0 = ovr_seen;
      busy_cnt = 0;
      align();
      fork
         begin
            io_rx = 1'b0;
            #(3 * CLK_PERIOD);
            io_rx = 1'b1;
         end
         for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (io_busy) busy_cnt++;
         end
      join
      check("glitch_busy_le_half", (busy_cnt <= HALF), 1);
      check("glitch_busy_seen", (busy_cnt > 0), 1);
      check("glitch_no_beat", beats - b0, 0);
      check("glitch_no_fe", fe_seen - f0, 0);
      check("glitch_no_ovr", ovr_seen - o0, 0);

      // Reset during data bit 4 of 0xFF, then 0xC3
      b0 = beats;
      align();
      fork
         uart_send(8'hFF, 1'b1, 1'b0);
         begin
            #(5 * BAUD_PERIOD + BAUD_PERIOD / 2);
            @(negedge clock);
            reset = 1'b0;
            #1;
            check("midrst_busy", io_busy, 0);
            check("midrst_valid", io_rx_valid, 0);
            repeat (2) @(posedge clock);
            @(negedge clock);
            reset = 1'b1;
         end
      join
      io_rx = 1'b1;
      #(2 * BAUD_PERIOD);
      align();
      uart_send(8'hC3, 1'b1, 1'b1);
      repeat (20) @(posedge clock);
      check("beats_after_reset", beats - b0, 1);

      // Model agreement at the end of the run
      check("exp_queue_drained", exp_q.size(), 0);
      check("fe_total", fe_seen, exp_fe);
      check("ovr_total", ovr_seen, exp_ovr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Synthesizable UART receiver. Consumes the serial line driven by the SimUart model's io_out in simulation, and the board RX pin on hardware.
- Deserializes 8N1 frames, LSB first.
- Presents each byte on a valid/ready (Decoupled) port to the MMIO/peripheral side.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLOCK_FREQ, 100_000_000: core clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in baud.
- DIVISOR, CLOCK_FREQ / BAUD_RATE (integer): clock cycles per bit. Must be >= 4. HALF = DIVISOR / 2 (integer).

Ports:
- clock, input, 1: core clock; all state on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- io_rx, input, 1: serial line, idle high, asynchronous to clock.
- io_rx_bits, output, 8: received byte.
- io_rx_valid, output, 1: io_rx_bits holds an unconsumed byte.
- io_rx_ready, input, 1: consumer accepts the byte this cycle.
- io_framing_error, output, 1: 1-cycle pulse; stop bit sampled low.
- io_overrun, output, 1: 1-cycle pulse; a completed byte was dropped because the holding register was full.
- io_busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (while reset low): io_rx_valid=0, io_rx_bits=0, io_framing_error=0, io_overrun=0, io_busy=0, FSM=IDLE, synchronizer flops=1, counters=0.
- Input synchronizer: io_rx passes through 2 flops to produce rx_s. All decisions use rx_s only.
- IDLE state: when rx_s==0 -> START, cycle counter=0.
- START state: count 0..HALF-1. At count==HALF-1, sample rx_s:
  - rx_s==1: glitch. Return to IDLE with no outputs.
  - rx_s==0: go to DATA, counter=0, bit_idx=0.
- DATA state: count 0..DIVISOR-1. At DIVISOR-1, shift rx_s into shift[bit_idx] (LSB first), increment bit_idx, counter=0. After bit_idx==7 is sampled -> STOP.
- STOP state: count 0..DIVISOR-1. At DIVISOR-1, sample rx_s:
  - rx_s==1: byte complete. Go to IDLE.
  - rx_s==0: io_framing_error pulses next cycle, byte discarded, go to WAIT_HIGH.
- WAIT_HIGH state: stay until rx_s==1, then IDLE. A break condition therefore never retriggers reception.
- Holding register (one entry), on byte complete:
  - io_rx_valid==0: load io_rx_bits and set io_rx_valid next cycle.
  - io_rx_valid==1 and io_rx_ready==1 in the same cycle: the new byte replaces the old one and io_rx_valid stays 1.
  - io_rx_valid==1 and io_rx_ready==0: new byte dropped, old byte retained, io_overrun pulses next cycle.
- Handshake: io_rx_valid clears the cycle after io_rx_valid&&io_rx_ready. It never deasserts without that handshake (except on reset). io_rx_bits is stable while valid.
- Latency: first cycle rx_s==0 to io_rx_valid high = HALF + 9*DIVISOR + 1 cycles. Add 2 cycles measured from io_rx.
- Sample points: every sample falls mid-bit, within ±1 cycle of the ideal point.
- Reset mid-frame: frame abandoned, nothing emitted. If the line is still low after reset, the remaining bits are treated as a new frame start. This is acceptable; the bench reasserts idle before the next frame.
- Simultaneous framing error and full holding register: only io_framing_error pulses; io_overrun does not.
- Counters: cycle counter width $clog2(DIVISOR); bit_idx 3 bits, no wrap beyond 7.

Decomposition:
- uart_pkg:
  - state enum {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - localparam function computing DIVISOR/HALF.
  - 8N1 constants (DATA_BITS=8, STOP_BITS=1).
- Sub-module sync_2ff: two-flop synchronizer with parameterized reset value (1 here). Reused later by uart_tx loopback and GPIO inputs.

Test Plan:
All tests use CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (DIVISOR=10), with SimUart BAUD_PERIOD=10_000 ns, io_rx_ready=1 unless stated.
- SimUart write 0x55 -> exactly one valid beat, io_rx_bits=0x55, io_framing_error=0, valid rises within [96,98] cycles of the io_rx falling edge.
- Back-to-back write 0xA5 then 0x3C -> two beats in order, 0xA5 then 0x3C. No io_overrun, io_busy low between frames.
- io_rx_ready=0; write 0x11 then 0x22 -> io_overrun pulses exactly once after the second frame. Then raise ready -> single beat 0x11, then io_rx_valid=0.
- Drive io_rx low for 10 bit periods (break), then high 2 periods, then write 0x7E -> one io_framing_error pulse and no beat for the break. The following beat is 0x7E.
- Drive io_rx low for 3 cycles then high -> io_busy pulses at most HALF cycles, no valid, no error pulses.
- Pull reset low for 2 cycles during data bit 4 of 0xFF, restore idle line, then write 0xC3 -> no beat for 0xFF, next beat 0xC3.
